// File: rtl/mux_selector_multicanal.sv
// -----------------------------------------------------------------------------
// mux_selector_multicanal
//
// Multi-channel selector with a single-word output register and a
// valid/ready handshake. A capture request copies the selected channel word
// into dato_out (and its index into canal_out), then holds it until the
// downstream side accepts it. A request that arrives while a word is still
// waiting, with no acceptance that cycle, is dropped and raises the sticky
// perdido flag.
//
// Optional feature: define MUX_SELECTOR_MULTICANAL_AUTOSCAN_EN to add an
// automatic scan mode (modo=1). In scan mode a dwell timer issues one request
// every DWELL cycles and walks the channel index 0..CHANNELS-1. Without the
// macro, modo is ignored and the block is always in manual mode.
//
// Parameters
//   WIDTH    : bits per channel word
//   CHANNELS : number of input channels (2..16)
//   DWELL    : cycles per channel in scan mode (1..2^20)
//   SELW     : derived index width, max(1, clog2(CHANNELS))
//
// Ports
//   clk       in  : clock, rising edge
//   reset     in  : synchronous active-high reset
//   datos     in  : packed channel words, channel k at [k*WIDTH +: WIDTH]
//   sel       in  : manual channel index
//   modo      in  : 0 manual, 1 scan (only with the macro)
//   cargar    in  : one-cycle manual capture request
//   listo     in  : downstream ready
//   limpiar   in  : clears perdido
//   dato_out  out : captured word (registered)
//   canal_out out : captured channel index (registered)
//   valido    out : a word is held and not yet accepted
//   perdido   out : sticky, at least one request was dropped
// -----------------------------------------------------------------------------
module mux_selector_multicanal #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 1000,
  localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH*CHANNELS-1:0] datos,
  input  logic [SELW-1:0]           sel,
  input  logic                      modo,
  input  logic                      cargar,
  input  logic                      listo,
  input  logic                      limpiar,
  output logic [WIDTH-1:0]          dato_out,
  output logic [SELW-1:0]           canal_out,
  output logic                      valido,
  output logic                      perdido
);

  typedef enum logic {
    ESPERA  = 1'b0,
    ENTREGA = 1'b1
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [WIDTH-1:0]  dato_n;
  logic [SELW-1:0]   canal_n;
  logic              perdido_n;

  logic              req;      // capture request this cycle
  logic [SELW-1:0]   idx;      // channel index for this request
  logic [WIDTH-1:0]  picked;   // datos[idx], zero when idx is out of range

`ifdef MUX_SELECTOR_MULTICANAL_AUTOSCAN_EN
  localparam int TW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [TW-1:0]   scan_timer;
  logic [SELW-1:0] scan_idx;
  logic            modo_q;
  logic            scan_req;

  // The cycle on which modo first rises is spent clearing the timer, so the
  // first scan capture lands DWELL cycles after that edge.
  assign scan_req = modo && modo_q && (scan_timer == TW'(DWELL - 1));

  // Dwell timer and scan index; both freeze while in manual mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_timer <= '0;
      scan_idx   <= '0;
      modo_q     <= 1'b0;
    end else begin
      modo_q <= modo;
      if (modo && !modo_q) begin
        scan_timer <= '0;
        scan_idx   <= '0;
      end else if (modo) begin
        if (scan_timer == TW'(DWELL - 1)) begin
          scan_timer <= '0;
          if (scan_idx == SELW'(CHANNELS - 1)) begin
            scan_idx <= '0;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end else begin
          scan_timer <= scan_timer + 1'b1;
        end
      end
    end
  end

  // Request source: scan timer in scan mode, cargar in manual mode.
  always_comb begin
    req = 1'b0;
    idx = sel;
    if (modo) begin
      req = scan_req;
      idx = scan_idx;
    end else begin
      req = cargar;
      idx = sel;
    end
  end
`else
  // modo has no meaning without the scan feature.
  logic unused_modo;
  assign unused_modo = modo;

  assign req = cargar;
  assign idx = sel;
`endif

  // Channel word selection; indices with no matching channel yield zero.
  always_comb begin
    picked = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == SELW'(k)) begin
        picked = datos[k*WIDTH +: WIDTH];
      end else begin
        picked = picked;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ESPERA;
      dato_out  <= '0;
      canal_out <= '0;
      perdido   <= 1'b0;
    end else begin
      state     <= state_n;
      dato_out  <= dato_n;
      canal_out <= canal_n;
      perdido   <= perdido_n;
    end
  end

  // Next state, next held word and drop detection.
  always_comb begin
    state_n   = state;
    dato_n    = dato_out;
    canal_n   = canal_out;
    perdido_n = perdido;
    if (limpiar) begin
      perdido_n = 1'b0;
    end else begin
      perdido_n = perdido;
    end
    case (state)
      ESPERA: begin
        if (req) begin
          dato_n  = picked;
          canal_n = idx;
          state_n = ENTREGA;
        end else begin
          state_n = ESPERA;
        end
      end
      ENTREGA: begin
        if (listo) begin
          // Accepted: a same-cycle request refills the register directly.
          if (req) begin
            dato_n  = picked;
            canal_n = idx;
            state_n = ENTREGA;
          end else begin
            state_n = ESPERA;
          end
        end else begin
          // Held word not accepted: a request is lost, and a drop wins
          // over a same-cycle limpiar.
          if (req) begin
            perdido_n = 1'b1;
          end else begin
            perdido_n = perdido_n;
          end
        end
      end
      default: begin
        state_n = ESPERA;
      end
    endcase
  end

  assign valido = (state == ENTREGA);

endmodule

// File: tb/tb_mux_selector_multicanal.sv
module tb_mux_selector_multicanal;

  logic        clk;
  logic        reset;
  // main instance: 4 channels
  logic [39:0] datos;
  logic [1:0]  sel;
  logic        modo;
  logic        cargar;
  logic        listo;
  logic        limpiar;
  logic [9:0]  dato_out;
  logic [1:0]  canal_out;
  logic        valido;
  logic        perdido;
  // second instance: 3 channels
  logic [29:0] datos3;
  logic [1:0]  sel3;
  logic        cargar3;
  logic        listo3;
  logic [9:0]  dato_out3;
  logic [1:0]  canal_out3;
  logic        valido3;
  logic        perdido3;

  int checks = 0;
  int errors = 0;

  mux_selector_multicanal #(.WIDTH(10), .CHANNELS(4), .DWELL(4)) dut (
    .clk(clk), .reset(reset), .datos(datos), .sel(sel), .modo(modo),
    .cargar(cargar), .listo(listo), .limpiar(limpiar),
    .dato_out(dato_out), .canal_out(canal_out), .valido(valido), .perdido(perdido)
  );

  mux_selector_multicanal #(.WIDTH(10), .CHANNELS(3), .DWELL(4)) dut3 (
    .clk(clk), .reset(reset), .datos(datos3), .sel(sel3), .modo(1'b0),
    .cargar(cargar3), .listo(listo3), .limpiar(1'b0),
    .dato_out(dato_out3), .canal_out(canal_out3), .valido(valido3), .perdido(perdido3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge, then settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++; if (dato_out !== 10'h000) begin errors++; $display("FAIL reset_dato got %h exp %h", dato_out, 10'h000); end
    checks++; if (canal_out !== 2'd0) begin errors++; $display("FAIL reset_canal got %0d exp %0d", canal_out, 0); end
    checks++; if (valido !== 1'b0) begin errors++; $display("FAIL reset_valido got %b exp 0", valido); end
    checks++; if (perdido !== 1'b0) begin errors++; $display("FAIL reset_perdido got %b exp 0", perdido); end
  endtask

  task automatic test_manual_capture();
    sel = 2'd2; cargar = 1'b1; listo = 1'b0;
    step();
    cargar = 1'b0;
    checks++; if (dato_out !== 10'h155) begin errors++; $display("FAIL cap_dato got %h exp %h", dato_out, 10'h155); end
    checks++; if (canal_out !== 2'd2) begin errors++; $display("FAIL cap_canal got %0d exp 2", canal_out); end
    checks++; if (valido !== 1'b1) begin errors++; $display("FAIL cap_valido got %b exp 1", valido); end
    sel = 2'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (dato_out !== 10'h155 || canal_out !== 2'd2 || valido !== 1'b1) begin
        errors++; $display("FAIL hold_%0d got %h/%0d/%b exp 155/2/1", i, dato_out, canal_out, valido);
      end
    end
  endtask

  task automatic test_drop();
    sel = 2'd1; cargar = 1'b1;
    step();
    cargar = 1'b0;
    checks++; if (dato_out !== 10'h155 || canal_out !== 2'd2) begin errors++; $display("FAIL drop_hold got %h/%0d exp 155/2", dato_out, canal_out); end
    checks++; if (perdido !== 1'b1) begin errors++; $display("FAIL drop_perdido got %b exp 1", perdido); end
    limpiar = 1'b1;
    step();
    limpiar = 1'b0;
    checks++; if (perdido !== 1'b0) begin errors++; $display("FAIL limpiar got %b exp 0", perdido); end
    // drop and limpiar together: drop wins
    cargar = 1'b1; limpiar = 1'b1;
    step();
    cargar = 1'b0; limpiar = 1'b0;
    checks++; if (perdido !== 1'b1) begin errors++; $display("FAIL drop_priority got %b exp 1", perdido); end
    limpiar = 1'b1;
    step();
    limpiar = 1'b0;
    checks++; if (perdido !== 1'b0) begin errors++; $display("FAIL limpiar2 got %b exp 0", perdido); end
    listo = 1'b1;
    step();
    checks++; if (valido !== 1'b0) begin errors++; $display("FAIL accept_valido got %b exp 0", valido); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_words [4];
    exp_words[0] = 10'h0A1; exp_words[1] = 10'h2B2; exp_words[2] = 10'h155; exp_words[3] = 10'h3C4;
    listo = 1'b1; cargar = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      step();
      checks++;
      if (canal_out !== 2'(i) || dato_out !== exp_words[i] || valido !== 1'b1 || perdido !== 1'b0) begin
        errors++; $display("FAIL b2b_%0d got %h/%0d/%b/%b exp %h/%0d/1/0", i, dato_out, canal_out, valido, perdido, exp_words[i], i);
      end
    end
    cargar = 1'b0;
    step();
    checks++; if (valido !== 1'b0) begin errors++; $display("FAIL b2b_end_valido got %b exp 0", valido); end
  endtask

  task automatic test_out_of_range();
    sel3 = 2'd3; cargar3 = 1'b1;
    step();
    cargar3 = 1'b0;
    checks++; if (dato_out3 !== 10'h000) begin errors++; $display("FAIL oor_dato got %h exp 000", dato_out3); end
    checks++; if (canal_out3 !== 2'd3) begin errors++; $display("FAIL oor_canal got %0d exp 3", canal_out3); end
    checks++; if (valido3 !== 1'b1) begin errors++; $display("FAIL oor_valido got %b exp 1", valido3); end
  endtask

  task automatic test_reset_mid();
    listo = 1'b0; sel = 2'd3; cargar = 1'b1;
    step();
    step();  // second request is dropped
    cargar = 1'b0;
    checks++; if (valido !== 1'b1 || perdido !== 1'b1 || dato_out !== 10'h3C4) begin
      errors++; $display("FAIL pre_reset got %h/%b/%b exp 3c4/1/1", dato_out, valido, perdido);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (dato_out !== 10'h000 || canal_out !== 2'd0 || valido !== 1'b0 || perdido !== 1'b0) begin
      errors++; $display("FAIL mid_reset got %h/%0d/%b/%b exp 000/0/0/0", dato_out, canal_out, valido, perdido);
    end
    sel = 2'd1; cargar = 1'b1;
    step();
    cargar = 1'b0;
    checks++; if (dato_out !== 10'h2B2 || canal_out !== 2'd1 || valido !== 1'b1) begin
      errors++; $display("FAIL post_reset got %h/%0d/%b exp 2b2/1/1", dato_out, canal_out, valido);
    end
    listo = 1'b1;
    step();
    checks++; if (valido !== 1'b0) begin errors++; $display("FAIL post_reset_accept got %b exp 0", valido); end
  endtask

`ifdef MUX_SELECTOR_MULTICANAL_AUTOSCAN_EN
  task automatic test_scan();
    int cap;
    // cargar/sel held active to show they are ignored in scan mode
    listo = 1'b1; cargar = 1'b1; sel = 2'd3; modo = 1'b1;
    step();  // rising modo clears timer and index
    cap = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++;
      if ((k % 4) == 0) begin
        if (valido !== 1'b1 || canal_out !== 2'(cap % 4)) begin
          errors++; $display("FAIL scan_k%0d got valido=%b canal=%0d exp 1/%0d", k, valido, canal_out, cap % 4);
        end
        cap++;
      end else begin
        if (valido !== 1'b0) begin
          errors++; $display("FAIL scan_idle_k%0d got valido=%b exp 0", k, valido);
        end
      end
    end
    modo = 1'b0; cargar = 1'b0;
    step();
  endtask
`else
  task automatic test_scan();
    // without scan support modo is ignored: cargar still captures
    listo = 1'b0; modo = 1'b1; sel = 2'd3; cargar = 1'b1;
    step();
    cargar = 1'b0;
    checks++; if (valido !== 1'b1 || canal_out !== 2'd3 || dato_out !== 10'h3C4) begin
      errors++; $display("FAIL modo_ignored got %h/%0d/%b exp 3c4/3/1", dato_out, canal_out, valido);
    end
    listo = 1'b1; modo = 1'b0;
    step();
    checks++; if (valido !== 1'b0) begin errors++; $display("FAIL modo_ignored_accept got %b exp 0", valido); end
  endtask
`endif

  initial begin
    reset = 1'b1; modo = 1'b0; cargar = 1'b0; listo = 1'b0; limpiar = 1'b0; sel = 2'd0;
    datos = {10'h3C4, 10'h155, 10'h2B2, 10'h0A1};
    datos3 = {10'h155, 10'h2B2, 10'h0A1};
    sel3 = 2'd0; cargar3 = 1'b0; listo3 = 1'b0;
    test_reset();
    test_manual_capture();
    test_drop();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    test_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_selector_multicanal.md
MUX_SELECTOR_MULTICANAL -- requirements
Module: mux_selector_multicanal

Interface
REQ-001 Parameter WIDTH, default 10: bit width of each channel word.
REQ-002 Parameter CHANNELS, default 4: number of input channels, legal range 2..16.
REQ-003 Parameter DWELL, default 1000: clock cycles per channel in scan mode, legal range 1..2^20.
REQ-004 Derived SELW = max(1, clog2(CHANNELS)), not overridable.
REQ-005 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port datos, input, WIDTH*CHANNELS: packed channel words; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 Port sel, input, SELW: manual channel index.
REQ-009 Port modo, input, 1: 0 = manual, 1 = scan (scan requires the macro).
REQ-010 Port cargar, input, 1: one-cycle manual capture request.
REQ-011 Port listo, input, 1: downstream ready.
REQ-012 Port limpiar, input, 1: clears the perdido flag.
REQ-013 Port dato_out, output, WIDTH: captured word, registered.
REQ-014 Port canal_out, output, SELW: index of the captured channel, registered.
REQ-015 Port valido, output, 1: dato_out/canal_out hold a word not yet accepted.
REQ-016 Port perdido, output, 1: sticky flag, at least one capture request was dropped.

Function
REQ-017 The block SHALL implement a two-state FSM: ESPERA (valido=0) and ENTREGA (valido=1).
REQ-018 A capture request SHALL be cargar=1 with modo=0 in manual mode, or the dwell terminal event in scan mode.
REQ-019 In ESPERA, a request SHALL register datos[idx] into dato_out and idx into canal_out, set valido at that edge, and move to ENTREGA; latency is 1 cycle.
REQ-020 In manual mode idx SHALL equal sel; in scan mode idx SHALL equal the internal scan index.
REQ-021 If idx >= CHANNELS, dato_out SHALL be all zeros and canal_out SHALL equal idx.
REQ-022 In ENTREGA, dato_out and canal_out SHALL remain stable until valido=1 and listo=1 are sampled together.
REQ-023 On acceptance with no request in the same cycle, the FSM SHALL clear valido and return to ESPERA.
REQ-024 On acceptance with a simultaneous request, the block SHALL capture the new word and stay in ENTREGA, sustaining one word per cycle.
REQ-025 A request in ENTREGA without acceptance SHALL be dropped, SHALL leave outputs unchanged, and SHALL set perdido at that edge.
REQ-026 limpiar=1 SHALL clear perdido; a drop in the same cycle SHALL take priority and leave perdido set.
REQ-027 In scan mode, cargar and sel SHALL be ignored.

Reset
REQ-028 With reset=1 at a clock edge, the block SHALL enter ESPERA and set dato_out=0, canal_out=0, valido=0, perdido=0, scan timer=0 and scan index=0.
REQ-029 Reset SHALL override every other input, including a reset asserted mid-ENTREGA, and the held word SHALL be discarded.

Configuration
REQ-030 With macro MUX_SELECTOR_MULTICANAL_AUTOSCAN_EN defined, scan logic SHALL be present:
- a timer counts 0..DWELL-1 while modo=1, and the terminal count raises a request for the current scan index;
- the scan index then increments and wraps from CHANNELS-1 to 0;
- a 0->1 transition of modo clears the timer and the scan index.
REQ-031 Without the macro, the timer and scan index SHALL not exist, modo SHALL be ignored, and the block SHALL always operate in manual mode.

Verification
REQ-032 Reset, then WIDTH=10, CHANNELS=4, datos ch2=10'h155, sel=2, cargar pulse, listo=0 -> next cycle dato_out=10'h155, canal_out=2, valido=1, held for 5 cycles.
REQ-033 In ENTREGA with listo=0, cargar pulse with sel=1 -> dato_out unchanged, perdido=1; limpiar pulse -> perdido=0.
REQ-034 listo=1 held, cargar held high for 4 cycles with sel=0,1,2,3 -> canal_out=0,1,2,3 on consecutive cycles, valido continuously 1, perdido=0.
REQ-035 CHANNELS=3, sel=3, cargar pulse -> dato_out=0, canal_out=3, valido=1.
REQ-036 Macro defined, DWELL=4, modo=1, listo=1 -> captures every 4 cycles with canal_out sequence 0,1,2,3,0.
REQ-037 reset asserted while valido=1 -> next cycle all outputs 0; a cargar pulse afterwards produces normal 1-cycle capture.
